// File: rtl/logic_stream_unit.sv
// logic_stream_unit: WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND) with valid/ready
// streams. Single-beat mode or multi-beat accumulate (reduction) mode; the result sits
// in a registered output until the consumer takes it.
// Optional feature macro: LOGIC_PARITY_EN adds out_parity = ^out_data.
module logic_stream_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LEN_W-1:0] out_beats
`ifdef LOGIC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [LEN_W-1:0] out_beats_q, out_beats_d;

  logic [1:0]       beat_op;
  logic [WIDTH-1:0] beat_r;
  logic [WIDTH-1:0] folded;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] res;
    unique case (o)
      2'b00:   res = x & y;
      2'b01:   res = x | y;
      2'b10:   res = x ^ y;
      default: res = ~(x & y);
    endcase
    return res;
  endfunction

  // Per-beat result and fold of that result into the running accumulator
  always_comb begin
    // First beat uses the live op; later beats use the op latched on the first beat
    beat_op = (state_q == StIdle) ? op : op_q;
    beat_r  = apply_op(beat_op, a, b);
    len_eff = (len == '0) ? LEN_W'(1) : len;
    cnt_inc = cnt_q + LEN_W'(1);
    unique case (op_q)
      2'b01:   folded = acc_q | beat_r;
      2'b10:   folded = acc_q ^ beat_r;
      default: folded = acc_q & beat_r;  // AND and NAND both reduce with &
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mode_d      = mode_q;
    len_d       = len_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d   = op;
          mode_d = mode;
          len_d  = len_eff;
          acc_d  = beat_r;
          cnt_d  = LEN_W'(1);
          if (!mode || len_eff == LEN_W'(1)) begin
            out_data_d  = beat_r;
            out_beats_d = LEN_W'(1);
            state_d     = StHold;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (in_valid) begin
          acc_d = folded;
          cnt_d = cnt_inc;
          if (!mode_q || cnt_inc == len_q) begin
            out_data_d  = folded;
            out_beats_d = len_q;
            state_d     = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial or pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      mode_q      <= 1'b0;
      len_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

`ifdef LOGIC_PARITY_EN
  logic parity_q;

  // Parity registered alongside out_data so the two never disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^out_data_d;
  end

  assign out_parity = parity_q;
`endif

  assign in_ready  = (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

endmodule

// File: tb/tb_logic_stream_unit.sv
// Testbench for logic_stream_unit: table-driven single-beat vectors, hand-written
// multi-cycle sequences, then randomized traffic against a transaction-level model.
module tb_logic_stream_unit;

  localparam int unsigned W = 8;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         mode;
  logic [L-1:0] len;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [L-1:0] out_beats;
`ifdef LOGIC_PARITY_EN
  logic         out_parity;
`endif

  int total = 0;
  int bad   = 0;

  logic_stream_unit #(.WIDTH(W), .LEN_W(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .mode      (mode),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats)
`ifdef LOGIC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gate(input logic [1:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Drive one beat starting at a negedge; returns at the following negedge
  task automatic beat(input logic m, input logic [1:0] o, input logic [L-1:0] l,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; mode = m; op = o; len = l; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] d, input logic [L-1:0] n);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(d));
    check({name, "_beats"}, 32'(out_beats), 32'(n));
    check({name, "_ready"}, 32'(in_ready), 32'd0);
`ifdef LOGIC_PARITY_EN
    check({name, "_parity"}, 32'(out_parity), 32'(^d));
`endif
  endtask

  typedef struct {
    logic         m;
    logic [1:0]   o;
    logic [L-1:0] l;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_d;
    logic [L-1:0] exp_n;
  } vec_t;

  vec_t vecs[9];

  // Transaction-level reference model state
  bit           m_hold;
  int           m_need;
  logic [1:0]   m_op;
  logic [W-1:0] m_vals[$];
  logic [W-1:0] m_exp_d;
  logic [L-1:0] m_exp_n;

  function automatic logic [W-1:0] reduce_vals(input logic [1:0] o);
    logic [W-1:0] acc;
    acc = m_vals[0];
    for (int i = 1; i < m_vals.size(); i++) begin
      if (o == 2'd1)      acc = acc | m_vals[i];
      else if (o == 2'd2) acc = acc ^ m_vals[i];
      else                acc = acc & m_vals[i];
    end
    return acc;
  endfunction

  initial begin
    vecs[0] = '{1'b0, 2'd0, 4'd0, 8'hF0, 8'h3C, 8'h30, 4'd1};
    vecs[1] = '{1'b1, 2'd1, 4'd0, 8'h0A, 8'h50, 8'h5A, 4'd1};  // len 0 acts as 1
    vecs[2] = '{1'b0, 2'd3, 4'd0, 8'hFF, 8'h0F, 8'hF0, 4'd1};
    vecs[3] = '{1'b0, 2'd1, 4'd0, 8'h12, 8'h40, 8'h52, 4'd1};
    vecs[4] = '{1'b0, 2'd2, 4'd0, 8'hAA, 8'hFF, 8'h55, 4'd1};
    vecs[5] = '{1'b1, 2'd2, 4'd1, 8'h0F, 8'hF0, 8'hFF, 4'd1};
    vecs[6] = '{1'b0, 2'd3, 4'd0, 8'h00, 8'h00, 8'hFF, 4'd1};
    vecs[7] = '{1'b0, 2'd0, 4'd5, 8'hC3, 8'h81, 8'h81, 4'd1};  // single mode ignores len
    vecs[8] = '{1'b0, 2'd1, 4'd0, 8'h30, 8'h01, 8'h31, 4'd1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0; mode = 1'b0; len = '0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_beats", 32'(out_beats), 32'd0);
`ifdef LOGIC_PARITY_EN
    check("rst_parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_valid", 32'(out_valid), 32'd0);

    // Single-beat table
    for (int i = 0; i < 9; i++) begin
      beat(vecs[i].m, vecs[i].o, vecs[i].l, vecs[i].x, vecs[i].y);
      check_result($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_n);
      consume($sformatf("vec%0d", i));
    end

    // Accumulate XOR over three beats; out_valid only after the third
    beat(1'b1, 2'd2, 4'd3, 8'h01, 8'h00);
    check("accx_b1_valid", 32'(out_valid), 32'd0);
    beat(1'b1, 2'd3, 4'd9, 8'h02, 8'h00);  // op/len changes must be ignored
    check("accx_b2_valid", 32'(out_valid), 32'd0);
    check("accx_b2_ready", 32'(in_ready), 32'd1);
    @(negedge clk);  // idle cycle in ACC must change nothing
    check("accx_gap_valid", 32'(out_valid), 32'd0);
    beat(1'b0, 2'd0, 4'd0, 8'h04, 8'h01);
    check_result("accx", 8'h06, 4'd3);
    consume("accx");

    // Accumulate NAND: per-beat NAND, folded with AND
    beat(1'b1, 2'd3, 4'd2, 8'hF0, 8'h0F);
    beat(1'b1, 2'd3, 4'd2, 8'h3C, 8'hFF);
    check_result("accn", 8'hFF & 8'hC3, 4'd2);
    consume("accn");

    // Backpressure: held result with in_valid high must not consume a beat
    beat(1'b0, 2'd0, 4'd0, 8'hF0, 8'h3C);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'd1; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d", i), {out_valid, in_ready, out_data, out_beats},
            {1'b1, 1'b0, 8'h30, 4'd1});
    end
    in_valid = 1'b0;
    consume("bp");

    // Reset in the middle of an accumulation
    beat(1'b1, 2'd0, 4'd4, 8'hFF, 8'hF0);
    beat(1'b1, 2'd0, 4'd4, 8'hFF, 8'h3C);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rel", 32'(out_valid), 32'd0);
    beat(1'b0, 2'd3, 4'd0, 8'hFF, 8'h0F);
    check_result("postrst", 8'hF0, 4'd1);
    consume("postrst");

    // Randomized traffic against the transaction-level model
    m_hold = 0;
    m_vals.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      a    = W'($urandom);
      b    = W'($urandom);
      op   = 2'($urandom);
      mode = ($urandom_range(0, 2) != 0);
      len  = L'($urandom_range(0, 6));
      @(posedge clk);
      if (m_hold) begin
        if (out_ready) m_hold = 0;
      end else if (in_valid) begin
        if (m_vals.size() == 0) begin
          m_op   = op;
          m_need = (!mode || len == 0) ? 1 : int'(len);
        end
        m_vals.push_back(gate(m_op, a, b));
        if (m_vals.size() == m_need) begin
          m_exp_d = reduce_vals(m_op);
          m_exp_n = L'(m_need);
          m_hold  = 1;
          m_vals.delete();
        end
      end
      @(negedge clk);
      check("rnd_valid", 32'(out_valid), 32'(m_hold));
      check("rnd_ready", 32'(in_ready), 32'(!m_hold));
      if (m_hold) begin
        check("rnd_data", 32'(out_data), 32'(m_exp_d));
        check("rnd_beats", 32'(out_beats), 32'(m_exp_n));
`ifdef LOGIC_PARITY_EN
        check("rnd_parity", 32'(out_parity), 32'(^m_exp_d));
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
